// File: rtl/vm_pkg.sv
// Shared constants, ASCII codes and writer state encoding for the text writer slice.
package vm_pkg;
    localparam int CH_COLS = 160;
    localparam int CH_ROWS = 60;
    localparam int CH_W    = 4;
    localparam int CH_H    = 8;
    localparam int ADDR_W  = 14;

    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_FF    = 8'h0C;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_TILDE = 8'h7E;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_CLEAR
    } state_t;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= ASCII_SPACE) && (c <= ASCII_TILDE);
    endfunction
endpackage

// File: rtl/vm_cursor.sv
// Text cursor: column/row counters with advance, newline, carriage return,
// backspace and home controls. Rows wrap to 0 (no scrolling).
module vm_cursor #(
    parameter int COLS = 160,
    parameter int ROWS = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       home,
    input  logic       inc,
    input  logic       newline,
    input  logic       cr,
    input  logic       backspace,
    output logic [7:0] col,
    output logic [5:0] row
);
    logic [7:0] col_q, col_d;
    logic [5:0] row_q, row_d;
    logic [5:0] row_next;

    assign row_next = (row_q == 6'(ROWS - 1)) ? 6'd0 : row_q + 6'd1;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (home) begin
            col_d = '0;
            row_d = '0;
        end else if (inc) begin
            if (col_q == 8'(COLS - 1)) begin
                col_d = '0;
                row_d = row_next;
            end else begin
                col_d = col_q + 8'd1;
            end
        end else if (newline) begin
            col_d = '0;
            row_d = row_next;
        end else if (cr) begin
            col_d = '0;
        end else if (backspace && (col_q != 8'd0)) begin
            col_d = col_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col = col_q;
    assign row = row_q;
endmodule

// File: rtl/vm_text_writer.sv
// Terminal-style character writer: accepts ASCII over valid/ready, interprets
// CR/LF/BS/FF and drives the character video memory write port.
module vm_text_writer #(
    parameter int CH_COLS        = 160,
    parameter int CH_ROWS        = 60,
    parameter int ADDR_W         = 14,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              write_clk,
    input  logic              write_rst,
    input  logic [7:0]        in_ch,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] vm_wr_addr,
    output logic [7:0]        vm_ch_out,
    output logic              vm_ch_write_enable,
    output logic [7:0]        cur_col,
    output logic [5:0]        cur_row
);
    import vm_pkg::*;

    localparam int CELLS = CH_COLS * CH_ROWS;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        ch_q, ch_d;
    logic              we_q, we_d;
    logic              adv_q, adv_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              cur_home, cur_inc, cur_nl, cur_cr, cur_bs;
    logic              accept;
    logic [ADDR_W-1:0] cell_addr;

    assign in_ready  = (state_q == ST_IDLE) && !write_rst;
    assign accept    = in_valid && in_ready;
    assign cell_addr = ADDR_W'(cur_row) * ADDR_W'(CH_COLS) + ADDR_W'(cur_col);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        ch_d      = ch_q;
        we_d      = 1'b0;
        adv_d     = adv_q;
        clr_cnt_d = clr_cnt_q;
        cur_home  = 1'b0;
        cur_inc   = 1'b0;
        cur_nl    = 1'b0;
        cur_cr    = 1'b0;
        cur_bs    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_printable(in_ch)) begin
                        addr_d  = cell_addr;
                        ch_d    = in_ch;
                        we_d    = 1'b1;
                        adv_d   = 1'b1;
                        state_d = ST_WRITE;
                    end else begin
                        case (in_ch)
                            ASCII_CR: cur_cr = 1'b1;
                            ASCII_LF: cur_nl = 1'b1;
                            ASCII_BS: begin
                                if (cur_col != 8'd0) begin
                                    // Cursor steps back now; the blank lands on the new position.
                                    cur_bs  = 1'b1;
                                    addr_d  = cell_addr - ADDR_W'(1);
                                    ch_d    = ASCII_SPACE;
                                    we_d    = 1'b1;
                                    adv_d   = 1'b0;
                                    state_d = ST_WRITE;
                                end
                            end
                            ASCII_FF: begin
                                clr_cnt_d = '0;
                                state_d   = ST_CLEAR;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_WRITE: begin
                cur_inc = adv_q;
                state_d = ST_IDLE;
            end
            ST_CLEAR: begin
                // Leave only once the final cell's strobe has been on the bus.
                if (clr_cnt_q == ADDR_W'(CELLS)) begin
                    cur_home = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    we_d      = 1'b1;
                    addr_d    = clr_cnt_q;
                    ch_d      = ASCII_SPACE;
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge write_clk) begin
        if (write_rst) begin
            state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            addr_q    <= '0;
            ch_q      <= '0;
            we_q      <= 1'b0;
            adv_q     <= 1'b0;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            ch_q      <= ch_d;
            we_q      <= we_d;
            adv_q     <= adv_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    vm_cursor #(
        .COLS(CH_COLS),
        .ROWS(CH_ROWS)
    ) u_cursor (
        .clk      (write_clk),
        .rst      (write_rst),
        .home     (cur_home),
        .inc      (cur_inc),
        .newline  (cur_nl),
        .cr       (cur_cr),
        .backspace(cur_bs),
        .col      (cur_col),
        .row      (cur_row)
    );

    assign vm_wr_addr         = addr_q;
    assign vm_ch_out          = ch_q;
    assign vm_ch_write_enable = we_q;
endmodule

// File: tb/tb_vm_text_writer.sv
// Self-checking bench for vm_text_writer: table vectors, corner sequences and
// random traffic against a screen/cursor reference model.
module tb_vm_text_writer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_ch = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [13:0] vm_addr;
    logic [7:0]  vm_ch;
    logic        vm_we;
    logic [7:0]  col;
    logic [5:0]  row;

    vm_text_writer #(
        .CH_COLS(160), .CH_ROWS(60), .ADDR_W(14), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .write_clk(clk), .write_rst(rst), .in_ch(in_ch), .in_valid(in_valid),
        .in_ready(in_ready), .vm_wr_addr(vm_addr), .vm_ch_out(vm_ch),
        .vm_ch_write_enable(vm_we), .cur_col(col), .cur_row(row)
    );

    always #5 clk = ~clk;

    localparam int COLS = 160;
    localparam int ROWS = 60;
    localparam int CELLS = COLS * ROWS;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct { int addr; int data; int cyc; } strobe_t;
    strobe_t sq[$];
    logic [7:0] dut_mem [CELLS];
    logic [7:0] ref_mem [CELLS];
    int m_col = 0;
    int m_row = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (vm_we) begin
            sq.push_back('{int'(vm_addr), int'(vm_ch), cyc});
            if (int'(vm_addr) < CELLS) dut_mem[vm_addr] = vm_ch;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Reference: screen contents and cursor from the terminal rules.
    // s: 0 no write, 1 single write (a,d), 2 full-screen sweep.
    task automatic model_byte(input logic [7:0] b, output int s, output int a, output int d);
        s = 0; a = 0; d = 0;
        if (b >= 8'h20 && b <= 8'h7E) begin
            s = 1; a = m_row * COLS + m_col; d = int'(b);
            ref_mem[a] = b;
            m_col++;
            if (m_col == COLS) begin m_col = 0; m_row = (m_row + 1) % ROWS; end
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h0A) begin
            m_col = 0; m_row = (m_row + 1) % ROWS;
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--; s = 1; a = m_row * COLS + m_col; d = 32;
                ref_mem[a] = 8'h20;
            end
        end else if (b == 8'h0C) begin
            s = 2; m_col = 0; m_row = 0;
            for (int i = 0; i < CELLS; i++) ref_mem[i] = 8'h20;
        end
    endtask

    // Called at negedge+1; returns the cycle number in which the byte was accepted.
    task automatic send(input logic [7:0] b, output int acc);
        int n;
        in_ch = b; in_valid = 1'b1; acc = -1; n = 0;
        while (acc < 0 && n < 20000) begin
            if (in_ready) acc = cyc;
            else begin @(negedge clk); #1; n++; end
        end
        if (acc < 0) $display("FAIL send_timeout actual=%0d expected=accept", n);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic wait_idle(input int budget, output int n);
        n = 0;
        while (!in_ready) begin
            if (n >= budget) begin n = -1; return; end
            @(negedge clk); #1;
            n++;
        end
    endtask

    task automatic chk_sweep(input string nm);
        int bad = 0;
        chk({nm, "_sweep_count"}, sq.size(), CELLS);
        foreach (sq[i]) if (sq[i].addr != i || sq[i].data != 32) bad++;
        chk({nm, "_sweep_order"}, bad, 0);
    endtask

    task automatic send_chk(input logic [7:0] b, input string nm);
        int s, a, d, acc, n;
        sq.delete();
        model_byte(b, s, a, d);
        send(b, acc);
        wait_idle(12000, n);
        chk({nm, "_idle"}, int'(n >= 0), 1);
        if (s == 2) chk_sweep(nm);
        else begin
            chk({nm, "_strobes"}, sq.size(), s);
            if (s == 1 && sq.size() == 1) begin
                chk({nm, "_addr"}, sq[0].addr, a);
                chk({nm, "_data"}, sq[0].data, d);
                chk({nm, "_lat"}, sq[0].cyc, acc + 1);
            end
        end
        chk({nm, "_col"}, int'(col), m_col);
        chk({nm, "_row"}, int'(row), m_row);
    endtask

    typedef struct { logic [7:0] b; int col; int row; int strobes; int addr; int data; } vec_t;
    vec_t vecs[$];

    initial begin
        int n, acc, s, a, d, bad, aq, dq, ar, dr;
        logic [7:0] b;

        vecs.push_back('{8'h48, 1, 0, 1, 0,   8'h48});
        vecs.push_back('{8'h69, 2, 0, 1, 1,   8'h69});
        vecs.push_back('{8'h08, 1, 0, 1, 1,   8'h20});
        vecs.push_back('{8'h0D, 0, 0, 0, 0,   0});
        vecs.push_back('{8'h0A, 0, 1, 0, 0,   0});
        vecs.push_back('{8'h08, 0, 1, 0, 0,   0});
        vecs.push_back('{8'h07, 0, 1, 0, 0,   0});
        vecs.push_back('{8'h80, 0, 1, 0, 0,   0});
        vecs.push_back('{8'h61, 1, 1, 1, 160, 8'h61});
        vecs.push_back('{8'h7E, 2, 1, 1, 161, 8'h7E});
        vecs.push_back('{8'h7F, 2, 1, 0, 0,   0});
        vecs.push_back('{8'h20, 3, 1, 1, 162, 8'h20});
        vecs.push_back('{8'h0A, 0, 2, 0, 0,   0});
        vecs.push_back('{8'h1F, 0, 2, 0, 0,   0});

        // Reset state and power-up sweep
        repeat (3) begin @(negedge clk); #1; end
        chk("rst_we", int'(vm_we), 0);
        chk("rst_addr", int'(vm_addr), 0);
        chk("rst_ch", int'(vm_ch), 0);
        chk("rst_col", int'(col), 0);
        chk("rst_row", int'(row), 0);
        chk("rst_ready", int'(in_ready), 0);
        sq.delete();
        rst = 1'b0;
        wait_idle(12000, n);
        chk("boot_idle", int'(n >= CELLS), 1);
        chk_sweep("boot");
        chk("boot_col", int'(col), 0);
        chk("boot_row", int'(row), 0);
        for (int i = 0; i < CELLS; i++) ref_mem[i] = 8'h20;

        // Table-driven vectors from a freshly cleared screen
        foreach (vecs[i]) begin
            sq.delete();
            model_byte(vecs[i].b, s, a, d);
            send(vecs[i].b, acc);
            wait_idle(100, n);
            chk($sformatf("vec%0d_strobes", i), sq.size(), vecs[i].strobes);
            if (vecs[i].strobes == 1 && sq.size() == 1) begin
                chk($sformatf("vec%0d_addr", i), sq[0].addr, vecs[i].addr);
                chk($sformatf("vec%0d_data", i), sq[0].data, vecs[i].data);
                chk($sformatf("vec%0d_lat", i), sq[0].cyc, acc + 1);
            end
            chk($sformatf("vec%0d_col", i), int'(col), vecs[i].col);
            chk($sformatf("vec%0d_row", i), int'(row), vecs[i].row);
        end

        // End-of-line and end-of-screen wrap
        send_chk(8'h0D, "cr");
        for (int i = 0; i < 58; i++) send_chk(8'h0A, "lf_wrap");
        chk("lf_wrap_row0", int'(row), 0);
        for (int i = 0; i < 159; i++) send_chk(8'h78, "fill0");
        send_chk(8'h41, "eol_A");
        chk("eol_A_addr", sq.size() == 1 ? sq[0].addr : -1, 159);
        chk("eol_A_pos", int'(col) * 100 + int'(row), 1);
        for (int i = 0; i < 58; i++) send_chk(8'h0A, "lf_down");
        for (int i = 0; i < 159; i++) send_chk(8'h78, "fill59");
        send_chk(8'h42, "eos_B");
        chk("eos_B_addr", sq.size() == 1 ? sq[0].addr : -1, 9599);
        chk("eos_B_pos", int'(col) * 100 + int'(row), 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            int r = $urandom_range(0, 99);
            if (r < 60) b = 8'($urandom_range(32, 126));
            else if (r < 70) b = 8'h0D;
            else if (r < 80) b = 8'h0A;
            else if (r < 90) b = 8'h08;
            else if (r < 95) b = 8'($urandom_range(8'h80, 8'hFF));
            else b = 8'($urandom_range(8'h0E, 8'h1F));
            send_chk(b, "rnd");
        end
        bad = 0;
        for (int i = 0; i < CELLS; i++) if (dut_mem[i] !== ref_mem[i]) bad++;
        chk("rnd_screen", bad, 0);

        // Form feed from (10,5)
        send_chk(8'h0D, "ff_pre_cr");
        for (int i = 0; i < 60 && m_row != 5; i++) send_chk(8'h0A, "ff_pre_lf");
        for (int i = 0; i < 10; i++) send_chk(8'h7A, "ff_pre_z");
        chk("ff_start_pos", int'(col) * 100 + int'(row), 1005);
        sq.delete();
        model_byte(8'h0C, s, a, d);
        send(8'h0C, acc);
        wait_idle(12000, n);
        chk("ff_busy", int'(n >= CELLS - 1), 1);
        chk_sweep("ff");
        chk("ff_pos", int'(col) * 100 + int'(row), 0);
        bad = 0;
        for (int i = 0; i < CELLS; i++) if (dut_mem[i] !== 8'h20) bad++;
        chk("ff_screen", bad, 0);

        // Reset in the middle of a sweep
        send_chk(8'h0A, "mid_lf");
        sq.delete();
        send(8'h0C, acc);
        n = 0;
        while (!(sq.size() > 0 && sq[$].addr == 4000) && n < 12000) begin
            @(negedge clk); #1; n++;
        end
        chk("mid_reach4000", int'(n < 12000), 1);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("mid_rst_we", int'(vm_we), 0);
        chk("mid_rst_addr", int'(vm_addr), 0);
        chk("mid_rst_ready", int'(in_ready), 0);
        chk("mid_rst_pos", int'(col) * 100 + int'(row), 0);
        rst = 1'b0;
        sq.delete();
        wait_idle(12000, n);
        chk_sweep("mid_restart");
        m_col = 0; m_row = 0;
        for (int i = 0; i < CELLS; i++) ref_mem[i] = 8'h20;

        // in_valid held across WRITE: second byte waits for in_ready
        send_chk(8'h0A, "hold_pre");
        sq.delete();
        model_byte(8'h51, s, aq, dq);
        model_byte(8'h52, s, ar, dr);
        in_ch = 8'h51; in_valid = 1'b1;
        chk("hold_ready0", int'(in_ready), 1);
        @(negedge clk); #1;
        chk("hold_busy", int'(in_ready), 0);
        chk("hold_we_q", int'(vm_we), 1);
        chk("hold_addr_q", int'(vm_addr), aq);
        in_ch = 8'h52;
        @(negedge clk); #1;
        chk("hold_ready2", int'(in_ready), 1);
        chk("hold_gap", int'(vm_we), 0);
        @(negedge clk); #1;
        in_valid = 1'b0;
        chk("hold_we_r", int'(vm_we), 1);
        chk("hold_addr_r", int'(vm_addr), ar);
        chk("hold_data_r", int'(vm_ch), dr);
        @(negedge clk); #1;
        chk("hold_count", sq.size(), 2);
        wait_idle(10, n);
        chk("hold_col", int'(col), m_col);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
